// File: rtl/md_pkg.sv
// Shared multiply/divide encodings and latency defaults. The D-stage decoder,
// the hazard unit and e_mdu all import these.
package md_pkg;

  localparam int CNT_W            = 4;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs fixed-latency
// MULT/DIV operations and raises the D-stage stall while one is in flight.
module e_mdu
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] e_A,
  input  logic [31:0] e_B,
  input  logic [3:0]  e_mdop,
  input  logic        d_is_md,
  output logic [31:0] e_mdout,
  output logic        e_start,
  output logic        e_busy,
  output logic        md_stall
);

  md_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [31:0]        hi, lo, hi_p, lo_p;
  logic [31:0]        hi_next, lo_next, hi_p_next, lo_p_next;
  logic [31:0]        res_hi, res_lo;
  logic               is_arith, is_div;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [32:0] a_w, b_w, quo_s, rem_s;

  assign is_arith = (e_mdop == MD_MULT) || (e_mdop == MD_MULTU) ||
                    (e_mdop == MD_DIV)  || (e_mdop == MD_DIVU);
  assign is_div   = (e_mdop == MD_DIV)  || (e_mdop == MD_DIVU);

  assign e_busy   = (state == ST_RUN);
  assign e_start  = is_arith && !e_busy;
  assign md_stall = d_is_md & (e_start | e_busy);

  always_comb begin
    e_mdout = 32'd0;
    if (e_mdop == MD_MFHI)      e_mdout = hi;
    else if (e_mdop == MD_MFLO) e_mdout = lo;
  end

  // Widened operands: 33-bit signed division keeps 0x80000000 / -1 exact,
  // so its low word is 0x80000000 with a zero remainder.
  assign prod_s = 64'($signed(e_A)) * 64'($signed(e_B));
  assign prod_u = 64'(e_A) * 64'(e_B);
  assign a_w    = {e_A[31], e_A};
  assign b_w    = {e_B[31], e_B};
  assign quo_s  = a_w / b_w;
  assign rem_s  = a_w % b_w;

  // Divide by zero parks the current HI/LO as the pending result.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (e_mdop)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: if (e_B != 32'd0) begin
        res_lo = quo_s[31:0];
        res_hi = rem_s[31:0];
      end
      MD_DIVU: if (e_B != 32'd0) begin
        res_lo = e_A / e_B;
        res_hi = e_A % e_B;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hi_next    = hi;
    lo_next    = lo;
    hi_p_next  = hi_p;
    lo_p_next  = lo_p;
    case (state)
      ST_IDLE: begin
        if (e_start) begin
          state_next = ST_RUN;
          cnt_next   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          hi_p_next  = res_hi;
          lo_p_next  = res_lo;
        end else if (e_mdop == MD_MTHI) begin
          hi_next = e_A;
        end else if (e_mdop == MD_MTLO) begin
          lo_next = e_A;
        end
      end
      ST_RUN: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_next    = hi_p;
          lo_next    = lo_p;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_p  <= 32'd0;
      lo_p  <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hi    <= hi_next;
      lo    <= lo_next;
      hi_p  <= hi_p_next;
      lo_p  <= lo_p_next;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: multiply/divide results, latency,
// divide corner cases, D-stage stall and mid-operation reset.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] e_A, e_B;
  logic [3:0]  e_mdop;
  logic        d_is_md;
  logic [31:0] e_mdout;
  logic        e_start, e_busy, md_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  e_mdu dut (
    .clk      (clk),
    .reset    (reset),
    .e_A      (e_A),
    .e_B      (e_B),
    .e_mdop   (e_mdop),
    .d_is_md  (d_is_md),
    .e_mdout  (e_mdout),
    .e_start  (e_start),
    .e_busy   (e_busy),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  // Nothing in the stimulus may issue an MD op into E while the unit is busy.
  always @(negedge clk) begin
    if (reset === 1'b1 && e_busy === 1'b1 && e_mdop >= 4'd1 && e_mdop <= 4'd8)
      $error("[TB] FAIL protocol: op %0d issued while busy", e_mdop);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic dmd);
    e_mdop  = op;
    e_A     = a;
    e_B     = b;
    d_is_md = dmd;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    apply_stimulus(4'd5, 32'd0, 32'd0, 1'b0);
    check_output({tag, " MFHI"}, e_mdout, exp_hi);
    apply_stimulus(4'd6, 32'd0, 32'd0, 1'b0);
    check_output({tag, " MFLO"}, e_mdout, exp_lo);
    apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Start an arithmetic op at cycle 0, then check busy through the run.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int cycles);
    apply_stimulus(op, a, b, 1'b0);
    check_output({tag, " e_start"}, {31'd0, e_start}, 32'd1);
    tick();
    apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= cycles; i++) begin
      check_output($sformatf("%s busy c%0d", tag, i), {31'd0, e_busy}, 32'd1);
      tick();
    end
    check_output({tag, " busy done"}, {31'd0, e_busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    check_output("rst e_busy",   {31'd0, e_busy},   32'd0);
    check_output("rst e_start",  {31'd0, e_start},  32'd0);
    check_output("rst md_stall", {31'd0, md_stall}, 32'd0);
    check_output("rst e_mdout",  e_mdout,           32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // Back-to-back issue at cycle 6: MULT -3 * 7 = -21
    run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd7, 5);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // DIV -7 / 2: quotient -3, remainder -1
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // MTHI / MTLO then DIVU by zero leaves HI/LO untouched
    apply_stimulus(4'd7, 32'h11, 32'd0, 1'b0);
    tick();
    apply_stimulus(4'd8, 32'h22, 32'd0, 1'b0);
    tick();
    read_hilo("mtx", 32'h11, 32'h22);
    run_op("divu0", 4'd4, 32'd5, 32'd0, 10);
    read_hilo("divu0", 32'h11, 32'h22);

    // DIV overflow case
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    read_hilo("divovf", 32'h0, 32'h8000_0000);

    // Stall: MULT 6 * 7 in E while D holds an MD op (MFLO)
    apply_stimulus(4'd1, 32'd6, 32'd7, 1'b1);
    check_output("stall c0", {31'd0, md_stall}, 32'd1);
    tick();
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(4'd0, 32'd0, 32'd0, 1'b1);
      check_output($sformatf("stall c%0d", i), {31'd0, md_stall}, 32'd1);
      tick();
    end
    apply_stimulus(4'd0, 32'd0, 32'd0, 1'b1);
    check_output("stall c6", {31'd0, md_stall}, 32'd0);
    apply_stimulus(4'd6, 32'd0, 32'd0, 1'b0);
    check_output("stall queued MFLO", e_mdout, 32'd42);
    apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0);
    tick();

    // Reset mid-operation: DIVU 100 / 7 aborted at cycle 4
    apply_stimulus(4'd4, 32'd100, 32'd7, 1'b0);
    tick();
    apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i < 4; i++) tick();
    check_output("abort busy c4", {31'd0, e_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_output("abort busy drop", {31'd0, e_busy}, 32'd0);
    read_hilo("abort rst", 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 5; i <= 12; i++) tick();
    check_output("abort busy c12", {31'd0, e_busy}, 32'd0);
    read_hilo("abort after", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
